// File: rtl/keypad_scanner.sv
// 3x3 key-matrix scanner: synchronises and debounces column returns and emits
// one cell code (1..9) per physical press for the game-state block.
module keypad_scanner #(
  parameter int CLK_DIV        = 25000,
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scan_en,
  input  logic [2:0] key_col,
  output logic [2:0] key_row,
  output logic [3:0] key_data,
  output logic       key_valid,
  output logic       key_held
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [3:0]    DB_LAST  = 4'(DEBOUNCE_TICKS);

  localparam logic [1:0] SCAN     = 2'd0;
  localparam logic [1:0] DEBOUNCE = 2'd1;
  localparam logic [1:0] EMIT     = 2'd2;
  localparam logic [1:0] RELEASE  = 2'd3;

  logic [2:0]    col_m, col_s;
  logic [CW-1:0] div_cnt;
  logic          tick;
  logic [1:0]    state;
  logic [3:0]    db_cnt, db_next;
  logic [3:0]    cand;
  logic [3:0]    row_base, col_off, code;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_m <= '0;
      col_s <= '0;
    end else begin
      col_m <= key_col;
      col_s <= col_m;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign tick    = (div_cnt == DIV_LAST);
  assign db_next = db_cnt + 4'd1;

  // Code 0 means no column active; a real candidate is never 0.
  always_comb begin
    row_base = 4'd6;
    if (key_row[0])      row_base = 4'd0;
    else if (key_row[1]) row_base = 4'd3;
    col_off = 4'd0;
    if (col_s[0])        col_off = 4'd1;
    else if (col_s[1])   col_off = 4'd2;
    else if (col_s[2])   col_off = 4'd3;
    code = (col_off == 4'd0) ? 4'd0 : row_base + col_off;
  end

  // Outputs are loaded on entry to EMIT so key_data is already valid while
  // key_valid is high for the single EMIT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SCAN;
      db_cnt    <= '0;
      cand      <= '0;
      key_row   <= 3'b001;
      key_data  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else if (!scan_en) begin
      state     <= SCAN;
      db_cnt    <= '0;
      key_row   <= 3'b001;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      case (state)
        SCAN: begin
          if (tick) begin
            if (col_s == 3'b000) begin
              key_row <= {key_row[1:0], key_row[2]};
            end else begin
              cand   <= code;
              db_cnt <= 4'd1;
              if (DEBOUNCE_TICKS == 1) begin
                state     <= EMIT;
                key_data  <= code;
                key_valid <= 1'b1;
                key_held  <= 1'b1;
              end else begin
                state <= DEBOUNCE;
              end
            end
          end
        end
        DEBOUNCE: begin
          if (tick) begin
            if (code == cand) begin
              db_cnt <= db_next;
              if (db_next == DB_LAST) begin
                state     <= EMIT;
                key_data  <= cand;
                key_valid <= 1'b1;
                key_held  <= 1'b1;
              end
            end else begin
              db_cnt <= '0;
              state  <= SCAN;
            end
          end
        end
        EMIT: begin
          db_cnt <= '0;
          state  <= RELEASE;
        end
        default: begin
          if (tick) begin
            if (col_s != 3'b000) begin
              db_cnt <= '0;
            end else if (db_next == DB_LAST) begin
              db_cnt   <= '0;
              key_held <= 1'b0;
              state    <= SCAN;
            end else begin
              db_cnt <= db_next;
            end
          end
        end
      endcase
    end
  end

endmodule
